// File: rtl/narb_rr_drain.sv
// Round-robin drain engine: pops flits from a bank of FIFOs and forwards them
// through a registered valid/ready stage, holding the link for a whole packet.
module narb_rr_drain #(
  parameter int NUM_PORTS      = 4,
  parameter int LOG2_NUM_PORTS = 2,
  parameter int FLIT_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]            fifo_enr,
  output logic                            out_valid,
  output logic [FLIT_WIDTH-1:0]           out_data,
  input  logic                            out_ready,
  output logic                            busy_o,
  output logic [LOG2_NUM_PORTS-1:0]       owner_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                state;
  logic [LOG2_NUM_PORTS-1:0] rr_ptr;
  logic [LOG2_NUM_PORTS-1:0] owner;

  logic [FLIT_WIDTH-1:0]     heads [NUM_PORTS];
  logic [LOG2_NUM_PORTS-1:0] winner;
  logic                      found;
  logic [LOG2_NUM_PORTS-1:0] sel;
  logic                      req;
  logic                      can_load;
  logic                      load;
  logic [FLIT_WIDTH-1:0]     sel_flit;
  logic                      sel_tail;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      heads[p] = fifo_data[p*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // Priority scan starting at rr_ptr; index arithmetic wraps at NUM_PORTS.
  always_comb begin
    logic [LOG2_NUM_PORTS-1:0] idx;
    // NOTE: every variable gets a default before any conditional write,
    // otherwise the tool infers a latch to hold the old value.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = rr_ptr + LOG2_NUM_PORTS'(i);
      if (!found && !fifo_empty[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    can_load = !out_valid || out_ready;
    sel      = (state == BUSY) ? owner : winner;
    req      = (state == BUSY) ? !fifo_empty[owner] : found;
    // Gating with rst keeps a flit from being popped and then thrown away.
    load     = req && can_load && !rst;
    fifo_enr = load ? (NUM_PORTS'(1) << sel) : '0;
    sel_flit = heads[sel];
    sel_tail = sel_flit[FLIT_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_flit;
        if (sel_tail) begin
          state  <= IDLE;
          rr_ptr <= sel + LOG2_NUM_PORTS'(1);
          owner  <= '0;
        end else begin
          state <= BUSY;
          owner <= sel;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy_o  = (state == BUSY);
  assign owner_o = owner;

endmodule

// File: tb/tb_narb_rr_drain.sv
// Directed bench for narb_rr_drain: queue-based FIFO models upstream and a
// scoreboard of expected output flits downstream.
module tb_narb_rr_drain;
  localparam int NP = 4;
  localparam int LG = 2;
  localparam int FW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    fifo_empty;
  logic [NP*FW-1:0] fifo_data;
  logic [NP-1:0]    fifo_enr;
  logic             out_valid;
  logic [FW-1:0]    out_data;
  logic             out_ready;
  logic             busy_o;
  logic [LG-1:0]    owner_o;

  narb_rr_drain #(.NUM_PORTS(NP), .LOG2_NUM_PORTS(LG), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_enr(fifo_enr), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [FW-1:0] exp_q[$];
  logic [NP-1:0] enr_s;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [FW-1:0] d);
    case (p)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic pop(input int p);
    case (p)
      0: if (q0.size() > 0) void'(q0.pop_front());
      1: if (q1.size() > 0) void'(q1.pop_front());
      2: if (q2.size() > 0) void'(q2.pop_front());
      default: if (q3.size() > 0) void'(q3.pop_front());
    endcase
  endtask

  task automatic refresh();
    fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    fifo_data  = {(q3.size() != 0) ? q3[0] : 8'h00, (q2.size() != 0) ? q2[0] : 8'h00,
                  (q1.size() != 0) ? q1[0] : 8'h00, (q0.size() != 0) ? q0[0] : 8'h00};
  endtask

  // One clock: observe handshake and enr mid-cycle, then model FIFO pops at the edge.
  task automatic tick();
    logic [FW-1:0] e;
    @(negedge clk);
    enr_s = fifo_enr;
    chk("enr_on_empty", enr_s & fifo_empty, 0);
    if (out_valid && out_ready && !rst) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_extra: observed=%0h expected=none", out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_flit", out_data, e);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete();
    end else begin
      for (int p = 0; p < NP; p++) if (enr_s[p]) pop(p);
    end
    refresh();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    refresh();
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_enr", fifo_enr, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_enr", fifo_enr, 0);

    // Single three-flit packet on port 0
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h83);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h83);
    refresh(); #1;
    chk("t1_enr0", fifo_enr, 4'b0001);
    chk("t1_busy0", busy_o, 0);
    tick();
    chk("t1_data1", out_data, 8'h01);
    chk("t1_busy1", busy_o, 1);
    chk("t1_enr1", fifo_enr, 4'b0001);
    tick();
    chk("t1_data2", out_data, 8'h02);
    chk("t1_busy2", busy_o, 1);
    chk("t1_enr2", fifo_enr, 4'b0001);
    tick();
    chk("t1_data3", out_data, 8'h83);
    chk("t1_busy3", busy_o, 0);
    chk("t1_enr3", fifo_enr, 0);
    tick();
    chk("t1_drained", out_valid, 0);

    // Fair arbitration after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) begin
      push(p, 8'h80 | 8'(p));
      exp_q.push_back(8'h80 | 8'(p));
    end
    refresh(); #1;
    for (int p = 0; p < NP; p++) begin
      chk("t2_enr", fifo_enr, 4'b0001 << p);
      tick();
      chk("t2_busy", busy_o, 0);
    end
    chk("t2_enr_done", fifo_enr, 0);
    chk("t2_last", out_data, 8'h83);

    // rr_ptr back at 0: port 0 beats port 2; leaves rr_ptr at 3
    push(0, 8'h84); push(2, 8'h86);
    exp_q.push_back(8'h84); exp_q.push_back(8'h86);
    refresh(); #1;
    chk("rr0_enr", fifo_enr, 4'b0001);
    tick();
    chk("rr0_enr2", fifo_enr, 4'b0100);
    tick();
    chk("rr0_enr3", fifo_enr, 0);

    // Wrap: rr_ptr=3 with ports 0 and 3 requesting, then reset mid-packet
    push(0, 8'h87); push(3, 8'h30); push(3, 8'h31);
    refresh(); #1;
    chk("t5_enr_wrap", fifo_enr, 4'b1000);
    tick();
    chk("t5_data", out_data, 8'h30);
    chk("t5_busy", busy_o, 1);
    chk("t5_owner", owner_o, 3);
    chk("t5_enr_busy", fifo_enr, 4'b1000);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_owner", owner_o, 0);
    chk("t5_rst_enr", fifo_enr, 0);
    rst = 1'b0;
    push(0, 8'h88); push(3, 8'hB3);
    exp_q.push_back(8'h88); exp_q.push_back(8'hB3);
    refresh(); #1;
    chk("t5_post_enr", fifo_enr, 4'b0001);
    tick();
    chk("t5_post_enr2", fifo_enr, 4'b1000);
    tick();
    chk("t5_post_data", out_data, 8'hB3);

    // Wormhole lock: port 1 bubbles mid-packet while port 2 waits
    push(1, 8'h11); push(2, 8'hA0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h92); exp_q.push_back(8'hA0);
    refresh(); #1;
    chk("t3_enr_first", fifo_enr, 4'b0010);
    tick();
    chk("t3_data11", out_data, 8'h11);
    for (int k = 0; k < 2; k++) begin
      chk("t3_gap_enr", fifo_enr, 0);
      chk("t3_gap_busy", busy_o, 1);
      chk("t3_gap_owner", owner_o, 1);
      tick();
    end
    chk("t3_gap_valid", out_valid, 0);
    chk("t3_gap_owner2", owner_o, 1);
    push(1, 8'h92);
    refresh(); #1;
    chk("t3_enr_tail", fifo_enr, 4'b0010);
    tick();
    chk("t3_data92", out_data, 8'h92);
    chk("t3_busy_done", busy_o, 0);
    chk("t3_enr_p2", fifo_enr, 4'b0100);
    tick();
    chk("t3_dataA0", out_data, 8'hA0);

    // Backpressure on a held flit
    push(0, 8'h05); push(0, 8'h86);
    exp_q.push_back(8'h05); exp_q.push_back(8'h86);
    refresh(); #1;
    chk("t4_enr_first", fifo_enr, 4'b0001);
    tick();
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_data", out_data, 8'h05);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_enr", fifo_enr, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume_enr", fifo_enr, 4'b0001);
    tick();
    chk("t4_data86", out_data, 8'h86);
    chk("t4_busy", busy_o, 0);
    tick();
    chk("t4_idle_valid", out_valid, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
